// File: rtl/crypt_engine_pkg.sv
// Shared widths, opcode values and FSM encoding for the command-driven crypt engine.
package crypt_engine_pkg;

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned DATA_W = 8;

   localparam logic [DATA_W-1:0] OP_HALT = 8'h00;
   localparam logic [DATA_W-1:0] OP_XOR  = 8'h01;
   localparam logic [DATA_W-1:0] OP_ADD  = 8'h02;
   localparam logic [DATA_W-1:0] OP_SUB  = 8'h03;
   localparam logic [DATA_W-1:0] OP_COPY = 8'h04;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FADDR,
      S_FWAIT,
      S_FCAP,
      S_DECODE,
      S_RADDR,
      S_RWAIT,
      S_WRITE,
      S_FINISH
   } state_t;

endpackage

// File: rtl/crypt_alu.sv
// Byte-wide combinational operator: src op key for the legal data opcodes.
module crypt_alu
   import crypt_engine_pkg::*;
(
   input  logic [DATA_W-1:0] opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

   // ADD/SUB wrap naturally at 8 bits; COPY and anything else pass src through.
   always_comb begin
      result = a;
      case (opcode)
         OP_XOR:  result = a ^ b;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         default: result = a;
      endcase
   end

endmodule

// File: rtl/crypt_engine.sv
// Command-program engine: fetches 4-byte records from cmd RAM and streams
// dst[a] = src[a] op key[a] through one-cycle-latency BSRAM ports.
module crypt_engine
   import crypt_engine_pkg::*;
(
   input  logic              sysclk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] mem_cmd_ad,
   output logic [ADDR_W-1:0] mem_src_ad,
   output logic [ADDR_W-1:0] mem_key_ad,
   output logic [ADDR_W-1:0] mem_dst_ad,
   output logic              mem_cmd_ce,
   output logic              mem_cmd_oce,
   output logic              mem_src_ce,
   output logic              mem_src_oce,
   output logic              mem_key_ce,
   output logic              mem_key_oce,
   output logic              mem_dst_ce,
   output logic              mem_dst_wre,
   output logic [DATA_W-1:0] mem_dst_din,
   input  logic [DATA_W-1:0] mem_cmd_dout,
   input  logic [DATA_W-1:0] mem_src_dout,
   input  logic [DATA_W-1:0] mem_key_dout
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [1:0]        fidx_q, fidx_d;
   logic [DATA_W-1:0] op_q, op_d;
   logic [5:0]        hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] len_q, len_d;
   logic [DATA_W-1:0] idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [ADDR_W-1:0] cmd_ad_q, cmd_ad_d;
   logic [ADDR_W-1:0] dat_ad_q, dat_ad_d;
   logic [ADDR_W-1:0] dst_ad_q, dst_ad_d;
   logic              cmd_rd_q, cmd_rd_d;
   logic              dat_rd_q, dat_rd_d;
   logic              dst_wr_q, dst_wr_d;
   logic [DATA_W-1:0] dst_din_q, dst_din_d;
   logic [DATA_W-1:0] alu_result;
   logic [ADDR_W-1:0] data_addr;

   // Current data byte address; the 14-bit sum wraps the address space.
   assign data_addr = {hi_q, lo_q} + ADDR_W'(idx_q);

   crypt_alu u_alu (
      .opcode (op_q),
      .a      (mem_src_dout),
      .b      (mem_key_dout),
      .result (alu_result)
   );

   // State and registered-output update.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         fidx_q    <= '0;
         op_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         cmd_ad_q  <= '0;
         dat_ad_q  <= '0;
         dst_ad_q  <= '0;
         cmd_rd_q  <= 1'b0;
         dat_rd_q  <= 1'b0;
         dst_wr_q  <= 1'b0;
         dst_din_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         fidx_q    <= fidx_d;
         op_q      <= op_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         cmd_ad_q  <= cmd_ad_d;
         dat_ad_q  <= dat_ad_d;
         dst_ad_q  <= dst_ad_d;
         cmd_rd_q  <= cmd_rd_d;
         dat_rd_q  <= dat_rd_d;
         dst_wr_q  <= dst_wr_d;
         dst_din_q <= dst_din_d;
      end
   end

   // Next state and next values of every registered output; strobes default low.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      fidx_d    = fidx_q;
      op_d      = op_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      len_d     = len_q;
      idx_d     = idx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = error_q;
      cmd_ad_d  = cmd_ad_q;
      dat_ad_d  = dat_ad_q;
      dst_ad_d  = dst_ad_q;
      cmd_rd_d  = 1'b0;
      dat_rd_d  = 1'b0;
      dst_wr_d  = 1'b0;
      dst_din_d = dst_din_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FADDR;
               pc_d    = '0;
               fidx_d  = '0;
               error_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_FADDR: begin
            cmd_ad_d = pc_q + ADDR_W'(fidx_q);
            cmd_rd_d = 1'b1;
            state_d  = S_FWAIT;
         end
         S_FWAIT: state_d = S_FCAP;
         S_FCAP: begin
            case (fidx_q)
               2'd0:    op_d  = mem_cmd_dout;
               2'd1:    hi_d  = mem_cmd_dout[5:0];
               2'd2:    lo_d  = mem_cmd_dout;
               default: len_d = mem_cmd_dout;
            endcase
            fidx_d  = fidx_q + 2'd1;
            state_d = (fidx_q == 2'd3) ? S_DECODE : S_FADDR;
         end
         S_DECODE: begin
            idx_d = '0;
            case (op_q)
               OP_HALT: state_d = S_FINISH;
               OP_XOR, OP_ADD, OP_SUB, OP_COPY: state_d = S_RADDR;
               default: begin
                  error_d = 1'b1;
                  state_d = S_FINISH;
               end
            endcase
         end
         S_RADDR: begin
            dat_ad_d = data_addr;
            dat_rd_d = 1'b1;
            state_d  = S_RWAIT;
         end
         S_RWAIT: state_d = S_WRITE;
         S_WRITE: begin
            dst_ad_d  = data_addr;
            dst_din_d = alu_result;
            dst_wr_d  = 1'b1;
            idx_d     = idx_q + 8'd1;
            // len of 0 ends after 256 bytes because len-1 wraps to 0xFF.
            if (idx_q == len_q - 8'd1) begin
               pc_d    = pc_q + ADDR_W'(4);
               state_d = S_FADDR;
            end else begin
               state_d = S_RADDR;
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign mem_cmd_ad  = cmd_ad_q;
   assign mem_src_ad  = dat_ad_q;
   assign mem_key_ad  = dat_ad_q;
   assign mem_dst_ad  = dst_ad_q;
   assign mem_cmd_ce  = cmd_rd_q;
   assign mem_cmd_oce = cmd_rd_q;
   assign mem_src_ce  = dat_rd_q;
   assign mem_src_oce = dat_rd_q;
   assign mem_key_ce  = dat_rd_q;
   assign mem_key_oce = dat_rd_q;
   assign mem_dst_ce  = dst_wr_q;
   assign mem_dst_wre = dst_wr_q;
   assign mem_dst_din = dst_din_q;

endmodule

// File: tb/tb_crypt_engine.sv
// Bench for crypt_engine: BSRAM models, a program-level reference model and
// a per-cycle compare process, plus directed and randomized programs.
module tb_crypt_engine;

   logic        sysclk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, error;
   logic [13:0] mem_cmd_ad, mem_src_ad, mem_key_ad, mem_dst_ad;
   logic        mem_cmd_ce, mem_cmd_oce, mem_src_ce, mem_src_oce;
   logic        mem_key_ce, mem_key_oce, mem_dst_ce, mem_dst_wre;
   logic [7:0]  mem_dst_din;
   logic [7:0]  mem_cmd_dout, mem_src_dout, mem_key_dout;

   crypt_engine dut (
      .sysclk(sysclk), .reset(reset), .start(start),
      .busy(busy), .done(done), .error(error),
      .mem_cmd_ad(mem_cmd_ad), .mem_src_ad(mem_src_ad),
      .mem_key_ad(mem_key_ad), .mem_dst_ad(mem_dst_ad),
      .mem_cmd_ce(mem_cmd_ce), .mem_cmd_oce(mem_cmd_oce),
      .mem_src_ce(mem_src_ce), .mem_src_oce(mem_src_oce),
      .mem_key_ce(mem_key_ce), .mem_key_oce(mem_key_oce),
      .mem_dst_ce(mem_dst_ce), .mem_dst_wre(mem_dst_wre),
      .mem_dst_din(mem_dst_din),
      .mem_cmd_dout(mem_cmd_dout), .mem_src_dout(mem_src_dout),
      .mem_key_dout(mem_key_dout)
   );

   always #5 sysclk = ~sysclk;

   logic [7:0] cmd_mem [0:16383];
   logic [7:0] src_mem [0:16383];
   logic [7:0] key_mem [0:16383];
   logic [7:0] dst_mem [0:16383];
   logic       fill_req = 1'b0;
   int         cyc = 0;
   int         wr_count = 0;

   // BSRAMs with one-cycle synchronous read; dst can be bulk-filled with 0xEE.
   always @(posedge sysclk) begin
      cyc <= cyc + 1;
      if (mem_cmd_ce && mem_cmd_oce) mem_cmd_dout <= cmd_mem[mem_cmd_ad];
      if (mem_src_ce && mem_src_oce) mem_src_dout <= src_mem[mem_src_ad];
      if (mem_key_ce && mem_key_oce) mem_key_dout <= key_mem[mem_key_ad];
      if (fill_req) begin
         for (int i = 0; i < 16384; i++) dst_mem[i] <= 8'hEE;
      end else if (mem_dst_ce && mem_dst_wre) begin
         dst_mem[mem_dst_ad] <= mem_dst_din;
         wr_count <= wr_count + 1;
      end
   end

   typedef struct { int a; int d; } wr_t;
   wr_t  exp_w [0:2047];
   int   exp_n, exp_lat, t0, run_id, seen_id, rd_idx;
   logic exp_err;
   logic mon_en;
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Walk the command program from address 0 and derive every dst write,
   // the final error flag and the cycle at which done must be seen.
   task automatic model_run(output int lat, output logic err, output int n);
      int pc, nrec, sum, op, base, len, a, s, k, d;
      pc = 0; nrec = 0; sum = 0; err = 1'b0; n = 0;
      for (int r = 0; r < 64; r++) begin
         op   = int'(cmd_mem[pc]);
         base = (int'(cmd_mem[(pc + 1) % 16384]) % 64) * 256 + int'(cmd_mem[(pc + 2) % 16384]);
         len  = int'(cmd_mem[(pc + 3) % 16384]);
         if (len == 0) len = 256;
         nrec++;
         if (op == 0) break;
         if (op > 4) begin err = 1'b1; break; end
         for (int i = 0; i < len; i++) begin
            a = (base + i) % 16384;
            s = int'(src_mem[a]);
            k = int'(key_mem[a]);
            case (op)
               1:       d = s ^ k;
               2:       d = (s + k) % 256;
               3:       d = (s - k + 256) % 256;
               default: d = s;
            endcase
            if (n < 2048) begin exp_w[n].a = a; exp_w[n].d = d; end
            n++;
         end
         sum += len;
         pc = (pc + 4) % 16384;
      end
      lat = 13 * nrec + 3 * sum + 1;
   endtask

   task automatic clear_cmd();
      for (int i = 0; i < 64; i++) cmd_mem[i] = 8'h00;
   endtask

   task automatic put_rec(input int idx, input int op, input int base, input int len);
      cmd_mem[idx * 4]     = 8'(op);
      cmd_mem[idx * 4 + 1] = 8'((base >> 8) & 63);
      cmd_mem[idx * 4 + 2] = 8'(base & 255);
      cmd_mem[idx * 4 + 3] = 8'(len);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_error"}, int'(error), 0);
      chk({tag, "_strobes"}, int'({mem_cmd_ce, mem_cmd_oce, mem_src_ce, mem_src_oce,
                                   mem_key_ce, mem_key_oce, mem_dst_ce, mem_dst_wre}), 0);
      chk({tag, "_addrs"}, int'({mem_cmd_ad, mem_src_ad, mem_key_ad, mem_dst_ad}), 0);
      chk({tag, "_din"}, int'(mem_dst_din), 0);
   endtask

   // Per-cycle comparison of busy/done/strobes/write stream against the model.
   task automatic monitor();
      int rel;
      forever begin
         @(negedge sysclk);
         if (mon_en) begin
            if (run_id != seen_id) begin seen_id = run_id; rd_idx = 0; end
            rel = cyc - t0;
            chk("busy", int'(busy), int'(rel < exp_lat));
            chk("done", int'(done), int'(rel == exp_lat));
            if (mem_dst_ce || mem_dst_wre) begin
               chk("wre_vs_ce", int'(mem_dst_wre), int'(mem_dst_ce));
               if (rd_idx < exp_n) begin
                  chk("dst_ad", int'(mem_dst_ad), exp_w[rd_idx].a);
                  chk("dst_din", int'(mem_dst_din), exp_w[rd_idx].d);
               end else begin
                  chk("extra_write", rd_idx, exp_n - 1);
               end
               rd_idx++;
            end
            if (rel >= exp_lat)
               chk("idle_strobes", int'({mem_cmd_ce, mem_cmd_oce, mem_src_ce, mem_src_oce,
                                         mem_key_ce, mem_key_oce, mem_dst_ce, mem_dst_wre}), 0);
         end
      end
   endtask

   // Run the program in cmd_mem; optionally re-pulse start while busy.
   task automatic run(input int extra_at, output int lat, output int nw, output logic err_o);
      int   n0;
      logic seen_done;
      model_run(exp_lat, exp_err, exp_n);
      n0 = wr_count;
      seen_done = 1'b0;
      lat = -1;
      @(negedge sysclk);
      start = 1'b1;
      @(posedge sysclk);
      #1;
      t0 = cyc;
      run_id++;
      mon_en = 1'b1;
      chk("error_cleared_on_start", int'(error), 0);
      for (int i = 0; i < 4000; i++) begin
         @(negedge sysclk);
         start = (i == extra_at) ? 1'b1 : 1'b0;
         if (done) begin
            seen_done = 1'b1;
            lat = cyc - t0;
            break;
         end
      end
      start = 1'b0;
      chk("done_seen", int'(seen_done), 1);
      err_o = error;
      repeat (3) @(negedge sysclk);
      mon_en = 1'b0;
      nw = wr_count - n0;
      chk("latency", lat, exp_lat);
      chk("error_flag", int'(err_o), int'(exp_err));
      chk("writes_seen", rd_idx, exp_n);
   endtask

   int   lat, nw, bad, n0;
   logic err;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mon_en = 1'b0;
      run_id = 0;
      seen_id = 0;
      rd_idx = 0;
      for (int i = 0; i < 16384; i++) begin
         cmd_mem[i] = 8'h00;
         src_mem[i] = 8'($urandom);
         key_mem[i] = 8'($urandom);
      end
      fork
         monitor();
      join_none
      fill_req = 1'b1;
      repeat (3) @(negedge sysclk);
      fill_req = 1'b0;
      chk_reset_vals("in_reset");
      reset = 1'b0;
      repeat (2) @(negedge sysclk);
      chk_reset_vals("after_reset");

      // XOR of four bytes at 0x10 with key 0x0F.
      clear_cmd();
      put_rec(0, 1, 16'h0010, 4);
      src_mem[16'h10] = 8'hAA; src_mem[16'h11] = 8'h55;
      src_mem[16'h12] = 8'hFF; src_mem[16'h13] = 8'h00;
      for (int i = 16'h10; i <= 16'h13; i++) key_mem[i] = 8'h0F;
      run(-1, lat, nw, err);
      chk("xor_lat_literal", lat, 39);
      chk("xor_writes_literal", nw, 4);
      chk("xor_dst", int'({dst_mem[16'h10], dst_mem[16'h11], dst_mem[16'h12], dst_mem[16'h13]}),
          32'hA55AF00F);

      // Second start pulse while busy must change nothing.
      for (int i = 16'h10; i <= 16'h13; i++) dst_mem[i] = dst_mem[i];
      run(10, lat, nw, err);
      chk("restart_lat", lat, 39);
      chk("restart_writes", nw, 4);
      chk("restart_dst", int'({dst_mem[16'h10], dst_mem[16'h11], dst_mem[16'h12], dst_mem[16'h13]}),
          32'hA55AF00F);

      // ADD wrapping from 0x3FFF to 0x0000.
      clear_cmd();
      put_rec(0, 2, 16'h3FFF, 2);
      src_mem[16'h3FFF] = 8'hFF; src_mem[0] = 8'h01;
      key_mem[16'h3FFF] = 8'h02; key_mem[0] = 8'hFF;
      run(-1, lat, nw, err);
      chk("wrap_dst_3fff", int'(dst_mem[16'h3FFF]), 8'h01);
      chk("wrap_dst_0000", int'(dst_mem[0]), 8'h00);
      chk("wrap_lat_literal", lat, 33);

      // len=0 COPY covers 256 bytes.
      clear_cmd();
      put_rec(0, 4, 16'h0100, 0);
      run(-1, lat, nw, err);
      chk("copy256_writes_literal", nw, 256);
      chk("copy256_lat_literal", lat, 795);
      bad = 0;
      for (int i = 16'h100; i <= 16'h1FF; i++) if (dst_mem[i] != src_mem[i]) bad++;
      chk("copy256_dst_bad_bytes", bad, 0);

      // Illegal opcode first, then a clean start clears error.
      clear_cmd();
      put_rec(0, 8'h7E, 16'h0040, 4);
      run(-1, lat, nw, err);
      chk("illegal_error_literal", int'(err), 1);
      chk("illegal_writes_literal", nw, 0);
      chk("illegal_lat_literal", lat, 14);
      clear_cmd();
      run(-1, lat, nw, err);
      chk("halt_only_error", int'(err), 0);
      chk("halt_only_lat_literal", lat, 14);

      // Randomized programs of one to three records.
      for (int t = 0; t < 8; t++) begin
         int nrec;
         clear_cmd();
         nrec = int'($urandom_range(1, 3));
         for (int r = 0; r < nrec; r++)
            put_rec(r, int'($urandom_range(1, 4)), int'($urandom_range(0, 16383)),
                    ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)));
         if ($urandom_range(0, 3) == 0) put_rec(nrec, int'($urandom_range(5, 255)), 0, 1);
         run(int'($urandom_range(0, 30)), lat, nw, err);
         chk("rand_write_count", nw, exp_n);
      end

      // Reset in the middle of a four-byte XOR after two writes.
      fill_req = 1'b1;
      @(negedge sysclk);
      fill_req = 1'b0;
      clear_cmd();
      put_rec(0, 1, 16'h0200, 4);
      n0 = wr_count;
      @(negedge sysclk);
      start = 1'b1;
      @(negedge sysclk);
      start = 1'b0;
      bad = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge sysclk);
         if (wr_count - n0 == 2) begin bad = 0; break; end
      end
      chk("abort_two_writes_seen", bad, 0);
      reset = 1'b1;
      #1;
      chk_reset_vals("abort");
      repeat (6) @(negedge sysclk);
      reset = 1'b0;
      repeat (6) @(negedge sysclk);
      chk("abort_write_count", wr_count - n0, 2);
      chk("abort_busy", int'(busy), 0);
      chk("abort_dst_written", int'({dst_mem[16'h200], dst_mem[16'h201]}),
          int'({src_mem[16'h200] ^ key_mem[16'h200], src_mem[16'h201] ^ key_mem[16'h201]}));
      chk("abort_dst_untouched", int'({dst_mem[16'h202], dst_mem[16'h203]}), 16'hEEEE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
